// File: rtl/dma_priority_resolver.sv
// DMA channel request resolver: synchronises DREQ, applies masks and
// polarity, picks one winner and holds the grant until service ends.
module dma_priority_resolver #(
    parameter int          NUM_CH   = 4,
    parameter logic [1:0]  LAST_RST = 2'd3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] soft_req,
    input  logic [NUM_CH-1:0] mask,
    input  logic              cmd_disable,
    input  logic              cmd_rotate,
    input  logic              cmd_dreq_low,
    input  logic              cmd_dack_high,
    input  logic              valid_dack,
    input  logic              svc_done,
    output logic [NUM_CH-1:0] valid_dreq,
    output logic [NUM_CH-1:0] DACK,
    output logic [1:0]        grant_ch,
    output logic              busy,
    output logic [NUM_CH-1:0] soft_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t            state;
    logic [NUM_CH-1:0] dreqS;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] dackInt;
    logic [1:0]        lastServed;
    logic [1:0]        winner;
    logic              winFound;

    function automatic logic [NUM_CH-1:0] oneHot(input logic [1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign pend = (dreqS | soft_req) & ~mask;
    assign busy = (state != IDLE);
    assign DACK = cmd_dack_high ? dackInt : ~dackInt;

    // Rotating scan starts just past the last served channel; the
    // 2-bit index wraps 3->0 naturally.
    always_comb begin
        logic [1:0] idx;
        winner   = 2'd0;
        winFound = 1'b0;
        idx      = 2'd0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = cmd_rotate ? lastServed + 2'(k) : 2'(k - 1);
            if (!winFound && pend[idx]) begin
                winner   = idx;
                winFound = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dreqS <= '0;
        end else begin
            dreqS <= DREQ ^ {NUM_CH{cmd_dreq_low}};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            valid_dreq <= '0;
            dackInt    <= '0;
            grant_ch   <= 2'd0;
            soft_clr   <= '0;
            lastServed <= LAST_RST;
        end else begin
            soft_clr <= '0;
            unique case (state)
                IDLE: begin
                    if (winFound && !cmd_disable) begin
                        grant_ch   <= winner;
                        valid_dreq <= oneHot(winner);
                        state      <= PEND;
                    end
                end
                PEND: begin
                    // An acknowledge beats a same-cycle withdrawal.
                    if (valid_dack) begin
                        dackInt <= oneHot(grant_ch);
                        state   <= SERV;
                    end else if (!pend[grant_ch]) begin
                        valid_dreq <= '0;
                        state      <= IDLE;
                    end
                end
                SERV: begin
                    if (svc_done) begin
                        valid_dreq <= '0;
                        dackInt    <= '0;
                        lastServed <= grant_ch;
                        if (soft_req[grant_ch]) begin
                            soft_clr <= oneHot(grant_ch);
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    valid_dreq <= '0;
                    dackInt    <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed and random checks of dma_priority_resolver against a
// cycle-level reference model of the arbitration rules.
module tb_dma_priority_resolver;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ, soft_req, mask;
    logic       cmd_disable, cmd_rotate, cmd_dreq_low, cmd_dack_high;
    logic       valid_dack, svc_done;
    logic [3:0] valid_dreq, DACK, soft_clr;
    logic [1:0] grant_ch;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // reference model
    logic [3:0] mDreqS;
    bit         mBusy, mAcked;
    int         mCh, mLast;
    logic [3:0] mSoftClr;

    dma_priority_resolver dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .soft_req(soft_req),
        .mask(mask), .cmd_disable(cmd_disable), .cmd_rotate(cmd_rotate),
        .cmd_dreq_low(cmd_dreq_low), .cmd_dack_high(cmd_dack_high),
        .valid_dack(valid_dack), .svc_done(svc_done),
        .valid_dreq(valid_dreq), .DACK(DACK), .grant_ch(grant_ch),
        .busy(busy), .soft_clr(soft_clr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] p);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = cmd_rotate ? (mLast + k) % 4 : k - 1;
            if (p[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic compareAll();
        logic [3:0] expV, expD;
        expV = mBusy ? 4'(1 << mCh) : 4'b0000;
        expD = mAcked ? 4'(1 << mCh) : 4'b0000;
        if (!cmd_dack_high) expD = ~expD;
        check("valid_dreq", valid_dreq, expV);
        check("DACK", DACK, expD);
        check("busy", {3'b000, busy}, {3'b000, mBusy});
        check("soft_clr", soft_clr, mSoftClr);
        if (mBusy) check("grant_ch", {2'b00, grant_ch}, 4'(mCh));
    endtask

    // Advance the model with the current inputs, clock, then compare.
    task automatic step();
        logic [3:0] p;
        int w;
        p = (mDreqS | soft_req) & ~mask;
        mSoftClr = 4'b0000;
        if (RESET) begin
            mDreqS = 4'b0000;
            mBusy  = 0;
            mAcked = 0;
            mCh    = 0;
            mLast  = 3;
        end else begin
            if (!mBusy) begin
                w = pick(p);
                if (w >= 0 && !cmd_disable) begin
                    mCh   = w;
                    mBusy = 1;
                end
            end else if (!mAcked) begin
                if (valid_dack) mAcked = 1;
                else if (!p[mCh]) mBusy = 0;
            end else if (svc_done) begin
                mBusy  = 0;
                mAcked = 0;
                mLast  = mCh;
                if (soft_req[mCh]) mSoftClr = 4'(1 << mCh);
            end
            mDreqS = DREQ ^ {4{cmd_dreq_low}};
        end
        @(posedge CLK);
        #1;
        compareAll();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ack();
        valid_dack = 1'b1; step(); valid_dack = 1'b0;
    endtask

    task automatic done();
        svc_done = 1'b1; step(); svc_done = 1'b0;
    endtask

    task automatic resetDut();
        DREQ = 4'b0000; soft_req = 4'b0000; mask = 4'b0000;
        cmd_disable = 0; cmd_rotate = 0; cmd_dreq_low = 0;
        cmd_dack_high = 0; valid_dack = 0; svc_done = 0;
        RESET = 1'b1;
        steps(2);
        RESET = 1'b0;
    endtask

    initial begin
        // 1: reset
        resetDut();
        step();
        check("t1 valid", valid_dreq, 4'b0000);
        check("t1 dack", DACK, 4'b1111);
        check("t1 busy", {3'b000, busy}, 4'b0000);
        check("t1 softclr", soft_clr, 4'b0000);

        // 2: fixed priority
        DREQ = 4'b1010;
        steps(2);
        check("t2 grant", valid_dreq, 4'b0010);
        ack();
        check("t2 dack", DACK, 4'b1101);
        steps(2);
        done();
        check("t2 dack off", DACK, 4'b1111);
        step();
        check("t2 regrant", valid_dreq, 4'b0010);

        // 3: rotating priority with wrap, then mask
        resetDut();
        cmd_rotate = 1'b1;
        DREQ = 4'b1010;
        steps(2);
        check("t3 first ch1", valid_dreq, 4'b0010);
        ack(); done(); step();
        check("t3 then ch3", valid_dreq, 4'b1000);
        ack(); done(); step();
        check("t3 wrap ch1", valid_dreq, 4'b0010);
        ack(); done();
        mask = 4'b0010;
        step();
        check("t3 masked ch3", valid_dreq, 4'b1000);
        ack(); done(); step();
        check("t3 masked again", valid_dreq, 4'b1000);

        // 4: withdrawal in PEND vs SERV
        resetDut();
        DREQ = 4'b0100;
        steps(2);
        check("t4 grant", valid_dreq, 4'b0100);
        DREQ = 4'b0000;
        steps(2);
        check("t4 withdrawn", valid_dreq, 4'b0000);
        check("t4 no dack", DACK, 4'b1111);
        DREQ = 4'b0100;
        steps(2);
        ack();
        DREQ = 4'b0000;
        mask = 4'b0100;
        cmd_disable = 1'b1;
        steps(3);
        check("t4 held", valid_dreq, 4'b0100);
        check("t4 dack held", DACK, 4'b1011);
        done();
        check("t4 released", valid_dreq, 4'b0000);

        // 5: polarity and soft request
        resetDut();
        cmd_dreq_low = 1'b1;
        cmd_dack_high = 1'b1;
        DREQ = 4'b1110;
        steps(2);
        check("t5 ch0", valid_dreq, 4'b0001);
        ack();
        check("t5 dack high", DACK, 4'b0001);
        cmd_dack_high = 1'b0;
        #1;
        check("t5 dack flip", DACK, 4'b1110);
        cmd_dack_high = 1'b1;
        DREQ = 4'b1111;
        done();
        soft_req = 4'b1000;
        step();
        check("t5 soft ch3", valid_dreq, 4'b1000);
        ack();
        done();
        check("t5 softclr", soft_clr, 4'b1000);
        soft_req = 4'b0000;
        step();
        check("t5 softclr pulse", soft_clr, 4'b0000);

        // 6: reset mid-SERV, controller disable
        resetDut();
        DREQ = 4'b0001;
        steps(2);
        ack();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("t6 rst busy", {3'b000, busy}, 4'b0000);
        check("t6 rst dack", DACK, 4'b1111);
        check("t6 rst grant", {2'b00, grant_ch}, 4'b0000);
        cmd_disable = 1'b1;
        DREQ = 4'b1111;
        steps(3);
        check("t6 disabled", valid_dreq, 4'b0000);

        // random traffic against the model
        resetDut();
        for (int i = 0; i < 600; i++) begin
            RESET       = ($urandom_range(0, 99) == 0);
            DREQ        = 4'($urandom);
            soft_req    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            mask        = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            valid_dack  = ($urandom_range(0, 3) == 0);
            svc_done    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) begin
                cmd_disable   = ($urandom_range(0, 3) == 0);
                cmd_rotate    = 1'($urandom);
                cmd_dreq_low  = 1'($urandom);
                cmd_dack_high = 1'($urandom);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
